lsu_mem_stage: RTL

//  Load/store stage between execute and the register-file writeback stage of the NPC core.

---
 rtl/lsu_mem_stage.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_stage.sv
// Load/store stage between execute and writeback: issues one bus access per accepted
// instruction, aligns/extends load data and emits the one-cycle shift commit pulse.
module lsu_mem_stage #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [2:0]        func3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]   wdata,
    output logic              bus_req_valid,
    input  logic              bus_req_ready,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [XLEN-1:0]   bus_wdata,
    output logic [7:0]        bus_wmask,
    input  logic              bus_rsp_valid,
    input  logic [XLEN-1:0]   bus_rdata,
    output logic [XLEN-1:0]   mem_rd_data,
    output logic              shift,
    output logic              misalign
);

    // state | meaning
    // IDLE  | ex_ready high, waiting for an instruction
    // REQ   | bus request held stable until bus_req_ready
    // WAIT  | waiting for read data or write ack
    // DONE  | one-cycle shift pulse, misalign qualifies it
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              is_load_q, is_load_d;
    logic              is_store_q, is_store_d;
    logic [2:0]        func3_q, func3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic              misalign_q, misalign_d;
    logic [XLEN-1:0]   rd_data_q, rd_data_d;

    // Legality of the instruction being offered, judged on the raw inputs.
    logic       in_is_load;
    logic       in_is_store;
    logic       in_aligned;
    logic       in_bad;

    always_comb begin
        in_is_load  = mem_rd;
        in_is_store = mem_wr & ~mem_rd;
        case (func3[1:0])
            2'b00:   in_aligned = 1'b1;
            2'b01:   in_aligned = ~addr[0];
            2'b10:   in_aligned = (addr[1:0] == 2'b00);
            default: in_aligned = (addr[2:0] == 3'b000);
        endcase
        in_bad = ~in_aligned
               | (in_is_load & (func3 == 3'b111))
               | (in_is_store & func3[2]);
    end

    logic [5:0]      lane_shamt;
    logic [XLEN-1:0] ld_raw;
    logic [XLEN-1:0] ld_ext;
    logic [XLEN-1:0] st_data;
    logic [7:0]      st_mask_base;
    logic [7:0]      st_mask;

    always_comb begin
        lane_shamt = {addr_q[2:0], 3'b000};
        ld_raw     = bus_rdata >> lane_shamt;
        case (func3_q)
            3'b000:  ld_ext = {{(XLEN-8){ld_raw[7]}}, ld_raw[7:0]};
            3'b001:  ld_ext = {{(XLEN-16){ld_raw[15]}}, ld_raw[15:0]};
            3'b010:  ld_ext = {{(XLEN-32){ld_raw[31]}}, ld_raw[31:0]};
            3'b011:  ld_ext = ld_raw;
            3'b100:  ld_ext = {{(XLEN-8){1'b0}}, ld_raw[7:0]};
            3'b101:  ld_ext = {{(XLEN-16){1'b0}}, ld_raw[15:0]};
            3'b110:  ld_ext = {{(XLEN-32){1'b0}}, ld_raw[31:0]};
            default: ld_ext = '0;
        endcase

        st_data = wdata_q << lane_shamt;
        case (func3_q[1:0])
            2'b00:   st_mask_base = 8'h01;
            2'b01:   st_mask_base = 8'h03;
            2'b10:   st_mask_base = 8'h0F;
            default: st_mask_base = 8'hFF;
        endcase
        st_mask = is_store_q ? (st_mask_base << addr_q[2:0]) : 8'h00;
    end

    always_comb begin
        state_d    = state_q;
        is_load_d  = is_load_q;
        is_store_d = is_store_q;
        func3_d    = func3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        misalign_d = misalign_q;
        rd_data_d  = rd_data_q;

        case (state_q)
            ST_IDLE: begin
                misalign_d = 1'b0;
                if (ex_valid) begin
                    is_load_d  = in_is_load;
                    is_store_d = in_is_store;
                    func3_d    = func3;
                    addr_d     = addr;
                    wdata_d    = wdata;
                    if ((mem_rd | mem_wr) && !in_bad) begin
                        state_d = ST_REQ;
                    end else begin
                        state_d = ST_DONE;
                        if (mem_rd | mem_wr) begin
                            misalign_d = 1'b1;
                            rd_data_d  = '0;
                        end
                    end
                end
            end
            ST_REQ: begin
                if (bus_req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Stores also wait here so the commit happens only after the write ack.
                if (bus_rsp_valid) begin
                    if (is_load_q) begin
                        rd_data_d = ld_ext;
                    end
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d    = ST_IDLE;
                misalign_d = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            is_load_q  <= 1'b0;
            is_store_q <= 1'b0;
            func3_q    <= 3'b000;
            addr_q     <= '0;
            wdata_q    <= '0;
            misalign_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            is_load_q  <= is_load_d;
            is_store_q <= is_store_d;
            func3_q    <= func3_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            misalign_q <= misalign_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Bus fields come straight from the latched instruction, so they cannot move while REQ stalls.
    always_comb begin
        ex_ready      = (state_q == ST_IDLE);
        bus_req_valid = (state_q == ST_REQ);
        bus_we        = bus_req_valid & is_store_q;
        bus_addr      = bus_req_valid ? {addr_q[ADDR_W-1:3], 3'b000} : '0;
        bus_wdata     = bus_we ? st_data : '0;
        bus_wmask     = bus_req_valid ? st_mask : 8'h00;
        mem_rd_data   = rd_data_q;
        shift         = (state_q == ST_DONE);
        misalign      = misalign_q;
    end

endmodule
